// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with LIFO return stack, branch/jump/call/return and halt control
module pc_stack_unit #(
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [18:0]            Instruction,
    input  logic                   BranchSel,
    input  logic                   JumpSel,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   StackSel,
    input  logic                   Halt,
    output logic [ADDR_W-1:0]      PC,
    output logic [$clog2(DEPTH):0] sp,
    output logic                   stack_empty,
    output logic                   stack_full,
    output logic                   stack_ovf,
    output logic                   stack_unf,
    output logic                   halted
);
    localparam int SP_W  = $clog2(DEPTH) + 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SP_W-1:0] FULL = SP_W'(DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              halted_q, halted_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [ADDR_W-1:0] stack_q [DEPTH];
    logic [ADDR_W-1:0] stack_d [DEPTH];

    logic [ADDR_W-1:0] seq, target, offset, top;
    logic [SP_W-1:0]   sp_m1;
    logic [IDX_W-1:0]  rd_idx, wr_idx;
    logic              empty, full, run, jump, do_pop, do_call, pop_ok, push_ok;
    logic              unused_instr;

    // Upper instruction bits carry no meaning for this unit
    assign unused_instr = ^Instruction[18:13];

    assign empty   = (sp_q == '0);
    assign full    = (sp_q == FULL);
    assign seq     = pc_q + ADDR_W'(1);
    assign target  = ADDR_W'(Instruction[12:0]);
    assign offset  = ADDR_W'($signed(Instruction[7:0]));
    assign sp_m1   = sp_q - SP_W'(1);
    assign rd_idx  = sp_m1[IDX_W-1:0];
    assign wr_idx  = sp_q[IDX_W-1:0];
    assign top     = stack_q[rd_idx];
    assign jump    = BranchSel && JumpSel;
    // Halt request or halted state freezes every piece of state this cycle
    assign run     = !(halted_q || Halt);
    // pop wins over push; a push only counts as a call when it rides on a jump
    assign do_pop  = run && pop;
    assign do_call = run && push && !pop && jump;
    assign pop_ok  = do_pop && !empty;
    assign push_ok = do_call && !full;

    // Next-state: PC priority chain, saturating stack pointer, sticky flags and the one stack write
    always_comb begin
        pc_d     = !run ? pc_q :
                   (pop && StackSel) ? (empty ? seq : top) :
                   jump ? target :
                   BranchSel ? seq + offset : seq;
        sp_d     = pop_ok ? sp_m1 : push_ok ? sp_q + SP_W'(1) : sp_q;
        halted_d = halted_q || Halt;
        ovf_d    = ovf_q || (do_call && full);
        unf_d    = unf_q || (do_pop && empty);
        stack_d  = stack_q;
        if (push_ok) stack_d[wr_idx] = seq;
    end

    // State registers; reset wipes the whole stack so no half-finished call survives
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= '0;
            sp_q     <= '0;
            halted_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
        end else begin
            pc_q     <= pc_d;
            sp_q     <= sp_d;
            halted_q <= halted_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            stack_q  <= stack_d;
        end
    end

    assign PC          = pc_q;
    assign sp          = sp_q;
    assign stack_empty = empty;
    assign stack_full  = full;
    assign stack_ovf   = ovf_q;
    assign stack_unf   = unf_q;
    assign halted      = halted_q;
endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: directed and randomized checks of pc_stack_unit against a queue-based model
module tb_pc_stack_unit;
    localparam int DEPTH = 8;
    localparam int MASK  = 'h1FFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [18:0] Instruction = '0;
    logic        BranchSel = 0, JumpSel = 0, push = 0, pop = 0, StackSel = 0, Halt = 0;
    logic [12:0] PC;
    logic [3:0]  sp;
    logic        stack_empty, stack_full, stack_ovf, stack_unf, halted;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 0;

    int m_pc = 0;
    int m_stk[$];
    bit m_halt = 0, m_ovf = 0, m_unf = 0;

    pc_stack_unit #(.ADDR_W(13), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .Instruction(Instruction),
        .BranchSel(BranchSel), .JumpSel(JumpSel), .push(push), .pop(pop),
        .StackSel(StackSel), .Halt(Halt), .PC(PC), .sp(sp),
        .stack_empty(stack_empty), .stack_full(stack_full),
        .stack_ovf(stack_ovf), .stack_unf(stack_unf), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference behaviour: a return stack as a queue, PC as plain modular arithmetic
    task automatic model_step();
        int seq, nxt;
        bit e;
        if (m_halt || Halt) begin
            m_halt = 1;
        end else begin
            seq = (m_pc + 1) & MASK;
            e = (m_stk.size() == 0);
            if (pop && StackSel) nxt = e ? seq : m_stk[$];
            else if (BranchSel && JumpSel) nxt = int'(Instruction[12:0]);
            else if (BranchSel) nxt = (seq + int'($signed(Instruction[7:0]))) & MASK;
            else nxt = seq;
            if (pop) begin
                if (e) m_unf = 1;
                else void'(m_stk.pop_back());
            end else if (push && BranchSel && JumpSel) begin
                if (m_stk.size() == DEPTH) m_ovf = 1;
                else m_stk.push_back(seq);
            end
            m_pc = nxt;
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc = 0;
            m_stk.delete();
            m_halt = 0;
            m_ovf = 0;
            m_unf = 0;
        end else begin
            model_step();
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_pc", int'(PC), m_pc);
            chk("model_sp", int'(sp), m_stk.size());
            chk("model_empty", int'(stack_empty), int'(m_stk.size() == 0));
            chk("model_full", int'(stack_full), int'(m_stk.size() == DEPTH));
            chk("model_ovf", int'(stack_ovf), int'(m_ovf));
            chk("model_unf", int'(stack_unf), int'(m_unf));
            chk("model_halted", int'(halted), int'(m_halt));
        end
    end

    task automatic cyc(input logic [18:0] ins, input logic bs, js, pu, po, ss, h);
        Instruction = ins;
        BranchSel = bs;
        JumpSel = js;
        push = pu;
        pop = po;
        StackSel = ss;
        Halt = h;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc('0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic call(input int t);
        cyc(19'(t), 1, 1, 1, 0, 0, 0);
    endtask

    task automatic ret();
        cyc('0, 0, 0, 0, 1, 1, 0);
    endtask

    task automatic do_reset();
        Instruction = '0;
        {BranchSel, JumpSel, push, pop, StackSel, Halt} = '0;
        rst = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int hcnt;
        logic [18:0] ins;
        int kind;
        #1 rst = 1'b0;
        cmp_on = 1;
        @(negedge clk);
        #1;
        chk("reset_pc", int'(PC), 0);
        chk("reset_sp", int'(sp), 0);
        chk("reset_empty", int'(stack_empty), 1);
        chk("reset_halted", int'(halted), 0);
        rst = 1'b1;

        // sequential wrap
        idle(1);
        chk("first_edge_pc", int'(PC), 1);
        idle(8190);
        chk("wrap_pre", int'(PC), 'h1FFF);
        idle(1);
        chk("wrap_post", int'(PC), 0);

        // branch
        do_reset();
        idle(16);
        chk("br_start", int'(PC), 'h010);
        cyc(19'h000FC, 1, 0, 0, 0, 0, 0);
        chk("br_back", int'(PC), 'h00D);
        cyc(19'h00005, 1, 0, 0, 0, 0, 0);
        chk("br_fwd", int'(PC), 'h013);

        // call/return
        idle(13);
        chk("call_start", int'(PC), 'h020);
        call('h100);
        chk("call_pc", int'(PC), 'h100);
        chk("call_sp", int'(sp), 1);
        ret();
        chk("ret_pc", int'(PC), 'h021);
        chk("ret_sp", int'(sp), 0);

        // overflow / underflow
        do_reset();
        for (int i = 0; i < 9; i++) call('h200 + 16 * i);
        chk("ovf_sp", int'(sp), 8);
        chk("ovf_flag", int'(stack_ovf), 1);
        chk("ovf_full", int'(stack_full), 1);
        chk("ovf_target", int'(PC), 'h280);
        for (int k = 0; k < 8; k++) begin
            ret();
            chk("lifo_ret", int'(PC), (k < 7) ? ('h261 - 16 * k) : 'h001);
        end
        chk("lifo_empty", int'(stack_empty), 1);
        chk("unf_pre", int'(stack_unf), 0);
        ret();
        chk("unf_flag", int'(stack_unf), 1);
        chk("unf_pc", int'(PC), 'h002);
        chk("unf_sp", int'(sp), 0);

        // halt then async reset mid-cycle
        do_reset();
        idle('h33);
        chk("halt_start", int'(PC), 'h033);
        cyc('0, 0, 0, 0, 0, 0, 1);
        chk("halt_pc", int'(PC), 'h033);
        chk("halt_flag", int'(halted), 1);
        for (int i = 0; i < 20; i++) begin
            cyc(19'($urandom), 1, 1, 1, 1'($urandom), 1'($urandom), 0);
            chk("halt_hold_pc", int'(PC), 'h033);
            chk("halt_hold_sp", int'(sp), 0);
            chk("halt_hold_flag", int'(halted), 1);
        end
        #2 rst = 1'b0;
        #1;
        chk("async_pc", int'(PC), 0);
        chk("async_halted", int'(halted), 0);
        rst = 1'b1;

        // simultaneous push&pop&StackSel
        do_reset();
        call('h100);
        call('h180);
        chk("sim_sp_pre", int'(sp), 2);
        cyc(19'h00300, 1, 1, 1, 1, 1, 0);
        chk("sim_sp", int'(sp), 1);
        chk("sim_pc", int'(PC), 'h101);
        ret();
        chk("sim_nowrite", int'(PC), 'h001);

        // randomized run against the model
        do_reset();
        hcnt = 0;
        for (int n = 0; n < 5000; n++) begin
            ins = 19'($urandom);
            kind = int'($urandom_range(0, 9));
            if (m_halt) begin
                hcnt++;
                if (hcnt > 5) begin
                    hcnt = 0;
                    do_reset();
                end
            end
            if ($urandom_range(0, 999) == 0) begin
                @(negedge clk);
                #3 rst = 1'b0;
                #2 rst = 1'b1;
            end
            case (kind)
                0, 1, 2: cyc(ins, 1, 1, 1, 1'($urandom_range(0, 5) == 0), 1'($urandom), 0);
                3, 4:    cyc(ins, 1'($urandom), 1'($urandom), 1'($urandom), 1, 1'($urandom), 0);
                5:       cyc(ins, 1, 0, 1'($urandom), 0, 0, 0);
                6:       cyc(ins, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                             1'($urandom), 1'($urandom_range(0, 150) == 0));
                default: cyc(ins, 0, 0, 1'($urandom), 0, 1'($urandom), 0);
            endcase
        end

        cmp_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_stack_unit.md
PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 Parameter ADDR_W, default 13, is the program-counter and return-address width in bits.
REQ-002 Parameter DEPTH, default 8, is the number of return-stack entries.
REQ-003 clk  input  1  is the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  is the reset: asynchronous, active-low.
REQ-005 Instruction  input  19  is the current instruction; [12:0] is the jump target and [7:0] is the signed branch offset.
REQ-006 BranchSel  input  1  is the controller branch-taken strobe.
REQ-007 JumpSel  input  1  is the controller absolute-jump select; it is only meaningful with BranchSel.
REQ-008 push  input  1  is the controller call strobe: push the return address.
REQ-009 pop  input  1  is the controller return strobe.
REQ-010 StackSel  input  1  selects the stack top as the next PC (return).
REQ-011 Halt  input  1  is the controller halt request.
REQ-012 PC  output  ADDR_W  is the registered program counter, driving instruction-memory address.
REQ-013 sp  output  log2(DEPTH)+1  is the current stack occupancy (0..DEPTH).
REQ-014 stack_empty / stack_full  output  1 each  are combinational flags: sp==0 and sp==DEPTH.
REQ-015 stack_ovf / stack_unf  output  1 each  are sticky error flags.
REQ-016 halted  output  1  is the registered halt state.

Function
REQ-017 The unit SHALL define seq = PC+1, computed modulo 2^ADDR_W.
REQ-018 The next-PC priority order SHALL be:
- (a) halted or Halt -> PC holds.
- (b) pop&StackSel -> stack top.
- (c) BranchSel&JumpSel -> Instruction[12:0], zero-extended to ADDR_W.
- (d) BranchSel alone -> seq + sign-extended Instruction[7:0], modulo 2^ADDR_W.
- (e) otherwise -> seq.
REQ-019 Halt SHALL set halted on the next edge; halted SHALL remain 1 until reset, and no PC, stack or flag change SHALL occur while halted or in the Halt cycle.
REQ-020 A call (push with BranchSel&JumpSel) SHALL write seq to entry sp, increment sp, and load the jump target, all on one edge.
REQ-021 Push when stack_full:
- stack_ovf SHALL set.
- The entry SHALL NOT be written and sp SHALL NOT change.
- The jump SHALL still be taken.
REQ-022 A return (pop&StackSel) SHALL load PC from entry sp-1 and decrement sp on one edge.
REQ-023 Pop when stack_empty:
- stack_unf SHALL set.
- sp SHALL stay 0.
- PC SHALL take seq.
REQ-024 pop without StackSel SHALL decrement sp (subject to REQ-023) without redirecting PC.
REQ-025 push and pop asserted together SHALL be treated as pop only; push is ignored.
REQ-026 push without BranchSel&JumpSel SHALL be ignored.
REQ-027 The stack top SHALL be readable combinationally so a return completes in one cycle; PC latency from any strobe to the new PC is exactly one clock edge.
REQ-028 The stack SHALL be LIFO with no wrap-around: sp saturates at 0 and DEPTH.

Reset
REQ-029 On rst low the unit SHALL asynchronously set PC=0, sp=0, halted=0, stack_ovf=0, stack_unf=0, and clear all stack entries to 0.
REQ-030 Reset asserted mid-call or mid-halt SHALL abort the operation, with no partial stack write surviving.
REQ-031 After rst deasserts, the first rising edge SHALL advance PC 0->1 when no strobes are active.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- Sequential wrap: reset, run idle 8192 edges -> PC returns to 0, with 0x1FFF->0x0000 observed.
- Branch: PC=0x010, BranchSel=1, Instruction[7:0]=0xFC -> PC=0x00D; then 0x05 -> PC=0x013.
- Call/return: PC=0x020, call to 0x100 -> PC=0x100, sp=1; next cycle pop&StackSel -> PC=0x021, sp=0.
- Overflow/underflow: 9 nested calls -> sp=8, stack_ovf=1, ninth target taken; 9 returns -> return addresses in LIFO order for 8, ninth gives stack_unf=1 and PC=seq.
- Halt: Halt at PC=0x033 -> PC holds 0x033 and halted=1 for 20 cycles despite BranchSel/push; async rst low mid-cycle -> PC=0, halted=0 immediately.
- Simultaneous: push&pop&StackSel with sp=2 -> sp=1, PC=entry1, no write.
